lm32_dtlb_walker: RTL and testbench
===================================

# lm32_dtlb_walker

Hardware page-table walker that refills the data TLB on a miss. It takes the faulting virtual address, fetches a two-level page table (10/10/12 split, 4 KiB pages) over a dedicated Wishbone master port, and emits a single-cycle update in TLB CSR format (vaddr/paddr word pair). It sits beside `lm32_dtlb` and writes the TLB that `lm32_dtlb` reads. Software refill through the TLB CSRs remains available, and the walker's update port is muxed onto the same TLB write path.

## Interface
Parameters:
- `page_size`, 4096: page size in bytes; only 4096 is supported.
- `pte_valid_bit`, 0: bit position of the valid flag in both the PDE and the PTE.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock; reset is synchronous and active-high.
- `enable`  in  1  walker enable; sampled only in IDLE.
- `ptbr`  in  32  page-table base; bits [11:0] ignored.
- `miss_req`  in  1  start a walk; level-sensitive, sampled in IDLE.
- `miss_vaddr`  in  32  faulting virtual address; latched at walk start.
- `busy`  out  1  high whenever state ≠ IDLE.
- `tlb_update`  out  1  one-cycle strobe; commits `tlb_vaddr`/`tlb_paddr`.
- `tlb_vaddr`  out  32  {vpn[31:12], 6'b0, 5'b0 cmd, 1'b1}.
- `tlb_paddr`  out  32  {pfn[31:12], 11'b0, 1'b1}.
- `fault`  out  1  one-cycle strobe: invalid PDE or PTE, or bus error.
- `fault_vaddr`  out  32  latched `miss_vaddr`, valid when `fault` is high.
- `d_adr_o`  out  32  Wishbone address.
- `d_cyc_o`, `d_stb_o`  out  1  Wishbone cycle and strobe.
- `d_we_o`  out  1  constant 0.
- `d_sel_o`  out  4  constant 4'hF.
- `d_cti_o`  out  3  constant 3'b000 (classic cycle).
- `d_dat_i`  in  32  read data.
- `d_ack_i`, `d_err_i`  in  1  Wishbone termination.

## Operation
- States: IDLE, L1, L2, UPDATE, FAULT. One-hot or binary encoding is allowed.
- **IDLE:** when `enable && miss_req`:
  - latch `va <= miss_vaddr`;
  - drive `d_adr_o <= {ptbr[31:12], miss_vaddr[31:22], 2'b00}`;
  - assert cyc/stb;
  - go to L1.
- **L1:** hold cyc/stb and address until `d_ack_i` or `d_err_i`.
  - `d_err_i` → FAULT. Error takes priority when ack and err arrive together.
  - ack with `d_dat_i[pte_valid_bit]==0` → FAULT.
  - Otherwise drive `d_adr_o <= {d_dat_i[31:12], va[21:12], 2'b00}` and go to L2. cyc/stb deassert for exactly one cycle between L1 and L2.
- **L2:** same termination rules as L1.
  - Valid PTE: latch `pfn <= d_dat_i[31:12]` → UPDATE.
- **UPDATE:** `tlb_update=1` for one cycle → IDLE.
- **FAULT:** `fault=1` for one cycle → IDLE. No TLB write occurs.
- `miss_req` outside IDLE is ignored.
- Once L1 is entered, `enable` has no effect; a walk always completes, because a Wishbone cycle cannot be abandoned without a termination.
- PTE bits [11:1] are ignored. Permission checking is out of scope.

## Timing
- Reset values: `busy`, `tlb_update`, `fault`, `d_cyc_o`, `d_stb_o` = 0; `d_adr_o`, `tlb_vaddr`, `tlb_paddr`, `fault_vaddr` = 0; state = IDLE.
- All outputs are registered.
- Latency from miss to update, with zero-wait slaves: `miss_req` sampled at edge N → cyc at N+1 → ack at N+1 → L2 cyc at N+3 → ack → `tlb_update` at N+5. Each slave wait state adds one cycle.
- `tlb_vaddr`/`tlb_paddr` are stable from the cycle `tlb_update` rises until the next walk starts.
- Reset asserted mid-walk: cyc/stb are low on the cycle after the reset edge. No `tlb_update` and no `fault` are produced. A stale ack arriving in IDLE is ignored.
- `busy` rises on the edge after `miss_req` is sampled and falls on the edge leaving UPDATE or FAULT.

## Structure
- Shared package / `lm32_include.v` holds:
  - state encodings `LM32_PTW_STATE_*`;
  - PDE/PTE field ranges (`LM32_PTE_PFN_RNG` = 31:12, L1 index 31:22, L2 index 21:12);
  - TLB CSR-format field positions, shared with `lm32_dtlb`.
- Single flat module; no sub-module is warranted, and the Wishbone request logic stays inline.
- The block is compiled only under `CFG_MMU_ENABLED`.

## Test plan
- Successful walk:
  - Stimulus: `ptbr=0x0010_0000`, `miss_vaddr=0x4000_3ABC`. L1 read at `0x0010_0400` returns `0x0020_0001`. L2 read at `0x0020_000C` returns `0x0ABC_D001`.
  - Required: one `tlb_update` with `tlb_vaddr=0x4000_3001` and `tlb_paddr=0x0ABC_D001`; latency N+5.
- Invalid PDE:
  - Stimulus: same addresses, L1 data `0x0020_0000`.
  - Required: `fault` pulses once with `fault_vaddr=0x4000_3ABC`; no L2 cycle occurs; no `tlb_update`.
- Bus error and wait states:
  - Stimulus: L2 stalls 3 cycles, then `d_ack_i` and `d_err_i` rise together.
  - Required: `fault` pulses; cyc/stb and `d_adr_o=0x0020_000C` are held for all 4 L2 cycles.
- Reset mid-walk:
  - Stimulus: `rst_i` asserted while in L2 awaiting ack.
  - Required: cyc/stb low the next cycle; no strobe; a later ack is ignored; a fresh walk then completes normally.
- Ignored requests:
  - Stimulus: `miss_req` toggled while `busy`; separately, `enable=0` with `miss_req=1` in IDLE.
  - Required: no extra Wishbone cycles; exactly one `tlb_update` per accepted walk.

Source files
------------

// File: rtl/lm32_dtlb_walker_pkg.sv
// Shared definitions for the LM32 data-TLB page-table walker:
// FSM state encodings, PDE/PTE field ranges and TLB CSR word formatting.
package lm32_dtlb_walker_pkg;

  typedef enum logic [2:0] {
    LM32_PTW_STATE_IDLE   = 3'd0,
    LM32_PTW_STATE_L1     = 3'd1,
    LM32_PTW_STATE_L2     = 3'd2,
    LM32_PTW_STATE_UPDATE = 3'd3,
    LM32_PTW_STATE_FAULT  = 3'd4
  } ptw_state_e;

  // 10/10/12 split of the virtual address; PFN lives in the same bits of PDE and PTE
  localparam int LM32_PTE_PFN_MSB = 31;
  localparam int LM32_PTE_PFN_LSB = 12;
  localparam int LM32_L1_IDX_MSB  = 31;
  localparam int LM32_L1_IDX_LSB  = 22;
  localparam int LM32_L2_IDX_MSB  = 21;
  localparam int LM32_L2_IDX_LSB  = 12;

  // TLB CSR vaddr word: {vpn, 6'b0, cmd(5), 1}; the walker always issues cmd 0
  function automatic logic [31:0] tlb_vaddr_word(input logic [19:0] vpn);
    return {vpn, 6'b0, 5'b0, 1'b1};
  endfunction

  function automatic logic [31:0] tlb_paddr_word(input logic [19:0] pfn);
    return {pfn, 11'b0, 1'b1};
  endfunction

endpackage

// File: rtl/lm32_dtlb_walker.sv
// Two-level hardware page-table walker refilling the LM32 data TLB on a miss.
// Issues classic Wishbone reads for PDE then PTE and emits one TLB CSR update or a fault.
module lm32_dtlb_walker
  import lm32_dtlb_walker_pkg::*;
#(
  parameter int page_size     = 4096,
  parameter int pte_valid_bit = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable,
  input  logic [31:0] ptbr,
  input  logic        miss_req,
  input  logic [31:0] miss_vaddr,
  output logic        busy,
  output logic        tlb_update,
  output logic [31:0] tlb_vaddr,
  output logic [31:0] tlb_paddr,
  output logic        fault,
  output logic [31:0] fault_vaddr,
  output logic [31:0] d_adr_o,
  output logic        d_cyc_o,
  output logic        d_stb_o,
  output logic        d_we_o,
  output logic [3:0]  d_sel_o,
  output logic [2:0]  d_cti_o,
  input  logic [31:0] d_dat_i,
  input  logic        d_ack_i,
  input  logic        d_err_i
);

  ptw_state_e  r_state, w_state_nxt;
  logic [31:0] r_va;
  logic [19:0] r_pfn;
  logic [31:0] r_adr;
  logic        r_cyc;
  logic        r_busy;
  logic        r_tlb_update;
  logic        r_fault;
  logic [31:0] r_tlb_vaddr;
  logic [31:0] r_tlb_paddr;
  logic [31:0] r_fault_vaddr;

  logic w_start;
  logic w_term;
  logic w_entry_ok;
  logic w_unused_ok;

  assign w_start    = (r_state == LM32_PTW_STATE_IDLE) && enable && miss_req;
  // Terminations only count while a cycle is actually open (stale acks ignored)
  assign w_term     = r_cyc && (d_ack_i || d_err_i);
  assign w_entry_ok = !d_err_i && d_dat_i[pte_valid_bit];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= LM32_PTW_STATE_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LM32_PTW_STATE_IDLE:
        if (w_start) w_state_nxt = LM32_PTW_STATE_L1;
      LM32_PTW_STATE_L1:
        if (w_term) w_state_nxt = w_entry_ok ? LM32_PTW_STATE_L2 : LM32_PTW_STATE_FAULT;
      LM32_PTW_STATE_L2:
        if (w_term) w_state_nxt = w_entry_ok ? LM32_PTW_STATE_UPDATE : LM32_PTW_STATE_FAULT;
      LM32_PTW_STATE_UPDATE: w_state_nxt = LM32_PTW_STATE_IDLE;
      LM32_PTW_STATE_FAULT:  w_state_nxt = LM32_PTW_STATE_IDLE;
      default:               w_state_nxt = LM32_PTW_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_va          <= '0;
      r_pfn         <= '0;
      r_adr         <= '0;
      r_cyc         <= 1'b0;
      r_busy        <= 1'b0;
      r_tlb_update  <= 1'b0;
      r_fault       <= 1'b0;
      r_tlb_vaddr   <= '0;
      r_tlb_paddr   <= '0;
      r_fault_vaddr <= '0;
    end else begin
      r_busy       <= (w_state_nxt != LM32_PTW_STATE_IDLE);
      r_tlb_update <= (r_state == LM32_PTW_STATE_UPDATE);
      r_fault      <= (r_state == LM32_PTW_STATE_FAULT);
      case (r_state)
        LM32_PTW_STATE_IDLE:
          if (w_start) begin
            r_va  <= miss_vaddr;
            r_adr <= {ptbr[31:12], miss_vaddr[LM32_L1_IDX_MSB:LM32_L1_IDX_LSB], 2'b00};
            r_cyc <= 1'b1;
          end
        LM32_PTW_STATE_L1:
          if (w_term) begin
            r_cyc <= 1'b0;
            if (w_entry_ok)
              r_adr <= {d_dat_i[LM32_PTE_PFN_MSB:LM32_PTE_PFN_LSB],
                        r_va[LM32_L2_IDX_MSB:LM32_L2_IDX_LSB], 2'b00};
          end
        LM32_PTW_STATE_L2:
          // First L2 cycle is the mandatory idle gap between the two bus cycles
          if (!r_cyc) begin
            r_cyc <= 1'b1;
          end else if (w_term) begin
            r_cyc <= 1'b0;
            r_pfn <= d_dat_i[LM32_PTE_PFN_MSB:LM32_PTE_PFN_LSB];
          end
        LM32_PTW_STATE_UPDATE: begin
          r_tlb_vaddr <= tlb_vaddr_word(r_va[31:12]);
          r_tlb_paddr <= tlb_paddr_word(r_pfn);
        end
        LM32_PTW_STATE_FAULT:
          r_fault_vaddr <= r_va;
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign tlb_update  = r_tlb_update;
  assign tlb_vaddr   = r_tlb_vaddr;
  assign tlb_paddr   = r_tlb_paddr;
  assign fault       = r_fault;
  assign fault_vaddr = r_fault_vaddr;
  assign d_adr_o     = r_adr;
  assign d_cyc_o     = r_cyc;
  assign d_stb_o     = r_cyc;
  assign d_we_o      = 1'b0;
  assign d_sel_o     = 4'hF;
  assign d_cti_o     = 3'b000;

  // Page offset of ptbr and PTE flag bits other than valid carry no meaning here
  assign w_unused_ok = ^{ptbr[11:0], d_dat_i[11:0], (page_size == 4096)};

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// Directed bench for lm32_dtlb_walker: memory-backed Wishbone slave, walk-outcome model,
// per-cycle compare of bus activity and TLB/fault strobes against the model.
module tb_lm32_dtlb_walker;

  logic        clk = 1'b0;
  logic        rst_i, enable, miss_req;
  logic [31:0] ptbr, miss_vaddr;
  logic        busy, tlb_update, fault;
  logic [31:0] tlb_vaddr, tlb_paddr, fault_vaddr;
  logic [31:0] d_adr_o, d_dat_i;
  logic        d_cyc_o, d_stb_o, d_we_o, d_ack_i, d_err_i;
  logic [3:0]  d_sel_o;
  logic [2:0]  d_cti_o;

  lm32_dtlb_walker #(.page_size(4096), .pte_valid_bit(0)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable(enable), .ptbr(ptbr), .miss_req(miss_req),
    .miss_vaddr(miss_vaddr), .busy(busy), .tlb_update(tlb_update), .tlb_vaddr(tlb_vaddr),
    .tlb_paddr(tlb_paddr), .fault(fault), .fault_vaddr(fault_vaddr), .d_adr_o(d_adr_o),
    .d_cyc_o(d_cyc_o), .d_stb_o(d_stb_o), .d_we_o(d_we_o), .d_sel_o(d_sel_o),
    .d_cti_o(d_cti_o), .d_dat_i(d_dat_i), .d_ack_i(d_ack_i), .d_err_i(d_err_i)
  );

  always #5 clk = ~clk;

  int nchk = 0, npass = 0;
  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Page-table memory seen by the slave
  logic [31:0] mem  [logic [31:0]];
  int          wst  [logic [31:0]];
  bit          errm [logic [31:0]];
  bit          stale_ack = 1'b0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction
  function automatic int waits(input logic [31:0] a);
    return wst.exists(a) ? wst[a] : 0;
  endfunction
  function automatic bit berr(input logic [31:0] a);
    return errm.exists(a) ? errm[a] : 1'b0;
  endfunction

  int wcnt = 0;
  always @(negedge clk) begin
    d_ack_i = stale_ack;
    d_err_i = 1'b0;
    if (d_cyc_o === 1'b1 && d_stb_o === 1'b1) begin
      if (wcnt < waits(d_adr_o)) wcnt++;
      else begin
        d_ack_i = 1'b1;
        d_err_i = berr(d_adr_o);
        d_dat_i = rd(d_adr_o);
        wcnt = 0;
      end
    end else wcnt = 0;
  end

  // Model: the expected bus accesses and the single terminating strobe of each walk
  typedef struct { logic [31:0] adr; int len; } acc_t;
  typedef struct { bit flt; int edge_n; logic [31:0] va; logic [31:0] pa; } ev_t;
  acc_t accq[$];
  ev_t  evq[$];

  // n = index of the clock edge that samples miss_req
  task automatic predict(input logic [31:0] pt, input logic [31:0] va, input int n);
    logic [31:0] a1, d1, a2, d2;
    int t1, t2;
    ev_t e;
    a1 = {pt[31:12], va[31:22], 2'b00};
    d1 = rd(a1);
    accq.push_back('{a1, 1 + waits(a1)});
    t1 = n + 1 + waits(a1);
    if (berr(a1) || !d1[0]) begin
      e = '{1'b1, t1 + 1, va, 32'h0}; evq.push_back(e); return;
    end
    a2 = {d1[31:12], va[21:12], 2'b00};
    d2 = rd(a2);
    accq.push_back('{a2, 1 + waits(a2)});
    t2 = t1 + 2 + waits(a2);   // one idle cycle, then the L2 cycle with its wait states
    if (berr(a2) || !d2[0]) e = '{1'b1, t2 + 1, va, 32'h0};
    else e = '{1'b0, t2 + 1, {va[31:12], 12'h001}, {d2[31:12], 12'h001}};
    evq.push_back(e);
  endtask

  // Compare process
  bit   prev_cyc = 1'b0, in_acc = 1'b0;
  acc_t cur;
  int   held = 0, bus_cnt = 0, upd_cnt = 0, flt_cnt = 0;
  int   last_edge = 0;
  logic [31:0] last_va, last_pa, last_fva;

  always @(negedge clk) begin
    if (rst_i !== 1'b0) begin
      in_acc = 1'b0;
    end else begin
      if (d_cyc_o) begin
        chk("wb_ctl", {d_stb_o, d_we_o, d_sel_o, d_cti_o}, {1'b1, 1'b0, 4'hF, 3'b000});
        chk("busy_in_cycle", busy, 1'b1);
        if (!prev_cyc) begin
          bus_cnt++;
          if (accq.size() == 0) begin
            chk("unexpected_cycle_adr", d_adr_o, 32'hFFFF_FFFF);
            in_acc = 1'b0;
          end else begin
            cur = accq.pop_front(); in_acc = 1'b1; held = 0;
          end
        end
        if (in_acc) begin
          chk("bus_adr", d_adr_o, cur.adr);
          held++;
        end
      end else if (prev_cyc && in_acc) begin
        chk("cycle_len", held, cur.len);
        in_acc = 1'b0;
      end
      if (tlb_update || fault) begin
        chk("busy_low_at_strobe", busy, 1'b0);
        if (tlb_update) upd_cnt++;
        if (fault) flt_cnt++;
        if (evq.size() == 0) chk("unexpected_strobe", {tlb_update, fault}, 2'b00);
        else begin
          ev_t e;
          e = evq.pop_front();
          chk("strobe_kind", {tlb_update, fault}, e.flt ? 2'b01 : 2'b10);
          chk("strobe_edge", ecnt, e.edge_n);
          if (e.flt) chk("fault_vaddr", fault_vaddr, e.va);
          else begin
            chk("tlb_vaddr", tlb_vaddr, e.va);
            chk("tlb_paddr", tlb_paddr, e.pa);
          end
          last_edge = ecnt; last_va = tlb_vaddr; last_pa = tlb_paddr; last_fva = fault_vaddr;
        end
      end else if (evq.size() > 0 && ecnt > evq[0].edge_n) begin
        chk("strobe_missing", 1'b0, 1'b1);
        void'(evq.pop_front());
      end
    end
    prev_cyc = (d_cyc_o === 1'b1);
  end

  int start_n;

  task automatic start_walk(input logic [31:0] pt, input logic [31:0] va);
    @(negedge clk);
    ptbr = pt; miss_vaddr = va; enable = 1'b1; miss_req = 1'b1;
    start_n = ecnt + 1;
    predict(pt, va, start_n);
  endtask

  task automatic wait_done(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk); #1;
      if (evq.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      chk({nm, "_timeout"}, 1'b0, 1'b1);
      evq.delete(); accq.delete();
    end
  endtask

  task automatic walk(input string nm, input logic [31:0] pt, input logic [31:0] va);
    start_walk(pt, va);
    @(negedge clk); miss_req = 1'b0;
    wait_done(nm);
  endtask

  int b0, u0, f0;

  initial begin
    rst_i = 1'b1; enable = 1'b0; miss_req = 1'b0; ptbr = '0; miss_vaddr = '0;
    d_dat_i = '0; d_ack_i = 1'b0; d_err_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {busy, tlb_update, fault, d_cyc_o, d_stb_o}, 5'b0);
    chk("rst_adr", d_adr_o, 32'h0);
    chk("rst_tlb", {tlb_vaddr, tlb_paddr}, 64'h0);
    chk("rst_fault_vaddr", fault_vaddr, 32'h0);
    chk("rst_wb_const", {d_we_o, d_sel_o, d_cti_o}, {1'b0, 4'hF, 3'b000});
    rst_i = 1'b0;

    // Successful walk, zero-wait slave
    mem[32'h0010_0400] = 32'h0020_0001;
    mem[32'h0020_000C] = 32'h0ABC_D001;
    b0 = bus_cnt; u0 = upd_cnt;
    walk("ok_walk", 32'h0010_0000, 32'h4000_3ABC);
    chk("ok_vaddr_lit", last_va, 32'h4000_3001);
    chk("ok_paddr_lit", last_pa, 32'h0ABC_D001);
    chk("ok_latency_lit", last_edge - start_n, 4);
    chk("ok_bus_count", bus_cnt - b0, 2);
    chk("ok_upd_count", upd_cnt - u0, 1);
    repeat (3) @(negedge clk);
    chk("tlb_words_stable", {tlb_vaddr, tlb_paddr}, {32'h4000_3001, 32'h0ABC_D001});

    // Invalid PDE: fault without any L2 cycle
    mem[32'h0010_0400] = 32'h0020_0000;
    b0 = bus_cnt; u0 = upd_cnt; f0 = flt_cnt;
    walk("bad_pde", 32'h0010_0000, 32'h4000_3ABC);
    chk("pde_fault_va_lit", last_fva, 32'h4000_3ABC);
    chk("pde_bus_count", bus_cnt - b0, 1);
    chk("pde_counts", {upd_cnt - u0, flt_cnt - f0}, {32'd0, 32'd1});

    // L2 stalls three cycles then ack+err together: error wins
    mem[32'h0010_0400] = 32'h0020_0001;
    wst[32'h0020_000C] = 3; errm[32'h0020_000C] = 1'b1;
    u0 = upd_cnt; f0 = flt_cnt;
    walk("l2_err", 32'h0010_0000, 32'h4000_3ABC);
    chk("err_latency_lit", last_edge - start_n, 7);
    chk("err_counts", {upd_cnt - u0, flt_cnt - f0}, {32'd0, 32'd1});
    wst.delete(); errm.delete();

    // L1 wait states; PTE flag bits set but valid clear, then set
    mem[32'h0030_0FFC] = 32'h0050_0001; wst[32'h0030_0FFC] = 2;
    mem[32'h0050_0004] = 32'h1234_5FFE;
    walk("bad_pte", 32'h0030_0ABC, 32'hFFC0_1234);
    mem[32'h0050_0004] = 32'h1234_5FFF;
    walk("top_walk", 32'h0030_0000, 32'hFFC0_1234);
    chk("top_paddr_lit", last_pa, 32'h1234_5001);
    chk("top_vaddr_lit", last_va, 32'hFFC0_1001);
    wst.delete();

    // Reset while L2 awaits ack
    wst[32'h0020_000C] = 20;
    b0 = bus_cnt; u0 = upd_cnt; f0 = flt_cnt;
    start_walk(32'h0010_0000, 32'h4000_3ABC);
    @(negedge clk); miss_req = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk); #1;
        if (d_cyc_o && d_adr_o == 32'h0020_000C) seen = 1'b1;
      end
      chk("reached_l2", seen, 1'b1);
    end
    rst_i = 1'b1; accq.delete(); evq.delete();
    @(posedge clk); @(negedge clk); #2;
    chk("rst_mid_cyc", {d_cyc_o, d_stb_o, busy}, 3'b000);
    rst_i = 1'b0;
    wst.delete();
    @(negedge clk); stale_ack = 1'b1;
    repeat (2) @(negedge clk); stale_ack = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_no_strobe", {upd_cnt - u0, flt_cnt - f0}, 64'h0);
    chk("rst_no_new_cycle", bus_cnt - b0, 2);
    walk("post_rst", 32'h0010_0000, 32'h4000_3ABC);
    chk("post_rst_upd", upd_cnt - u0, 1);

    // Disabled walker ignores requests
    b0 = bus_cnt;
    @(negedge clk); enable = 1'b0; miss_req = 1'b1;
    repeat (5) @(negedge clk);
    miss_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("disabled_no_cycle", bus_cnt - b0, 0);

    // Requests while busy and enable dropped mid-walk are ignored
    b0 = bus_cnt; u0 = upd_cnt;
    start_walk(32'h0010_0000, 32'h4000_3ABC);
    @(negedge clk); miss_req = 1'b0; enable = 1'b0;
    @(negedge clk); miss_req = 1'b1;
    @(negedge clk); miss_req = 1'b0;
    wait_done("busy_toggle");
    repeat (4) @(negedge clk);
    chk("toggle_bus_count", bus_cnt - b0, 2);
    chk("toggle_upd_count", upd_cnt - u0, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
